// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, opcodes and datapath select encodings for the multicycle controller.
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_4      = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/mc_immdec.sv
// mc_immdec: opcode to immediate-format select; J format only exists when MC_JAL_EN is defined.
module mc_immdec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);
`ifdef MC_JAL_EN
  logic w_jal;
  assign w_jal = op == OP_JAL;
`else
  logic w_jal;
  assign w_jal = 1'b0;
`endif
  assign ImmSrc = op == OP_SW  ? IMM_S :
                  op == OP_BEQ ? IMM_B :
                  w_jal        ? IMM_J : IMM_I;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the RV32I multicycle datapath.
// Define MC_JAL_EN to include the JAL state and its decode.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic [3:0] state
);
  state_t r_state;
  state_t w_st;
  state_t w_dec;
  logic   w_jal;
  logic   w_pcupdate, w_branch, w_memwrite, w_irwrite, w_regwrite, w_done;
`ifdef MC_JAL_EN
  assign w_jal = op == OP_JAL;
`else
  assign w_jal = 1'b0;
`endif
  assign w_dec = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                 op == OP_R   ? S_EXECR :
                 op == OP_I   ? S_EXECI :
                 op == OP_BEQ ? S_BEQ   :
                 w_jal        ? S_JAL   : S_FETCH;
  always_ff @(posedge clk)
    if (reset) r_state <= S_FETCH;
    else
      case (r_state)
        S_FETCH:   r_state <= S_DECODE;
        S_DECODE:  r_state <= w_dec;
        S_MEMADR:  r_state <= op == OP_LW ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: r_state <= S_MEMWB;
        S_EXECR:   r_state <= S_ALUWB;
        S_EXECI:   r_state <= S_ALUWB;
`ifdef MC_JAL_EN
        S_JAL:     r_state <= S_ALUWB;
`endif
        default:   r_state <= S_FETCH;
      endcase
  // Reset decodes as FETCH so the datapath sees sane selects while held.
  assign w_st = reset ? S_FETCH : r_state;
  always_comb begin
    w_pcupdate = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_done     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_ADD;
    case (w_st)
      S_FETCH: begin
        w_irwrite  = 1'b1;
        w_pcupdate = 1'b1;
        ALUSrcB    = SRCB_4;
        ResultSrc  = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        w_done  = w_dec == S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_4;
        w_pcupdate = 1'b1;
      end
`endif
      S_BEQ: begin
        ALUSrcA  = SRCA_RS1;
        ALUOp    = ALUOP_SUB;
        w_branch = 1'b1;
        w_done   = 1'b1;
      end
      default: ;
    endcase
  end
  assign PCWrite    = !reset && (w_pcupdate || (w_branch && Zero));
  assign MemWrite   = !reset && w_memwrite;
  assign IRWrite    = !reset && w_irwrite;
  assign RegWrite   = !reset && w_regwrite;
  assign instr_done = !reset && w_done;
  assign state      = r_state;
  mc_immdec u_immdec (.op(op), .ImmSrc(ImmSrc));
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: instruction-level reference model driving directed and random opcodes.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] state;
  int n_tests = 0;
  int n_fail = 0;
`ifdef MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .instr_done(instr_done), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".pcwrite"}, PCWrite, 0);
    check({tag, ".irwrite"}, IRWrite, 0);
    check({tag, ".regwrite"}, RegWrite, 0);
    check({tag, ".memwrite"}, MemWrite, 0);
    check({tag, ".done"}, instr_done, 0);
    check({tag, ".alusrcb"}, ALUSrcB, 2);
    check({tag, ".resultsrc"}, ResultSrc, 2);
  endtask

  // Called at 1ns after an edge with the DUT expected in FETCH; abort_at < 0 runs to completion.
  task automatic run_instr(input logic [6:0] o, input logic z, input int abort_at);
    int p[$];
    bit is_lw, is_sw, is_r, is_i, is_bq, is_jl, wr, last;
    is_lw = o == LW; is_sw = o == SW; is_r = o == RT;
    is_i = o == IT; is_bq = o == BQ; is_jl = JAL_EN && o == JL;
    if (is_lw) p = '{0, 1, 2, 3, 4};
    else if (is_sw) p = '{0, 1, 2, 5};
    else if (is_r) p = '{0, 1, 6, 7};
    else if (is_i) p = '{0, 1, 8, 7};
    else if (is_bq) p = '{0, 1, 10};
    else if (is_jl) p = '{0, 1, 9, 7};
    else p = '{0, 1};
    wr = is_lw || is_r || is_i || is_jl;
    for (int k = 0; k < p.size(); k++) begin
      last = k == p.size() - 1;
      op = o;
      Zero = last ? z : 1'($urandom);
      #1;
      check("state", state, p[k]);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check_quiet("abort");
        @(posedge clk); #1;
        check("abort.state", state, 0);
        reset = 1'b0;
        return;
      end
      check("done", instr_done, last);
      check("regwrite", RegWrite, last && wr);
      check("memwrite", MemWrite, last && is_sw);
      check("irwrite", IRWrite, k == 0);
      check("adrsrc", AdrSrc, (is_lw || is_sw) && k == 3);
      check("pcwrite", PCWrite, k == 0 || (is_jl && k == 2) || (is_bq && last && Zero));
      if (k == 0) check("immsrc", ImmSrc, is_sw ? 1 : is_bq ? 2 : (JAL_EN && o == JL) ? 3 : 0);
      if ((is_r || is_i) && k == 2) begin
        check("exec.alusrcb", ALUSrcB, is_i ? 1 : 0);
        check("exec.aluop", ALUOp, 2);
      end
      if (is_bq && last) check("beq.aluop", ALUOp, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] o;
    int idx;
    ops = '{LW, SW, RT, IT, BQ, JL, 7'b0000000};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_quiet("reset");
      check("reset.state", state, 0);
    end
    reset = 1'b0;
    run_instr(LW, 1'b0, -1);
    run_instr(SW, 1'b0, -1);
    run_instr(BQ, 1'b1, -1);
    run_instr(BQ, 1'b0, -1);
    run_instr(RT, 1'b0, -1);
    run_instr(IT, 1'b0, -1);
    run_instr(JL, 1'b1, -1);
    run_instr(7'b0000000, 1'b0, -1);
    run_instr(LW, 1'b0, 3);
    run_instr(LW, 1'b0, -1);
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 7);
      o = idx == 7 ? 7'($urandom) : ops[idx];
      run_instr(o, 1'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
